// File: rtl/exe_pipe_if.sv
// Decode/writeback bundle for the execute stage.
// master = surrounding pipeline, slave = exe_pipe.
interface exe_pipe_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] reg1_val;
  logic [WIDTH-1:0] reg2_val;
  logic [WIDTH-1:0] immediate;
  logic [2:0]       alu_oc;
  logic             ir_op;
  logic             set_flags;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [31:0]      wr_cpsr_val;
  logic             busy;

  modport master (
    output flush, in_valid, reg1_val, reg2_val, immediate, alu_oc, ir_op, set_flags, out_ready,
    input  in_ready, out_valid, result, wr_cpsr_val, busy
  );

  modport slave (
    input  flush, in_valid, reg1_val, reg2_val, immediate, alu_oc, ir_op, set_flags, out_ready,
    output in_ready, out_valid, result, wr_cpsr_val, busy
  );
endinterface

// File: rtl/exe_pipe.sv
// Registered execute stage (ALU + NZCV): latency 1, MUL takes WIDTH cycles unless EXE_PIPE_FAST_MUL_EN.
// Result held in HOLD until out_ready; in_ready drops while MUL iterates or the output is stalled.
module exe_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst_n,
  exe_pipe_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

  localparam logic [2:0] OC_ADD = 3'd0;
  localparam logic [2:0] OC_SUB = 3'd1;
  localparam logic [2:0] OC_AND = 3'd2;
  localparam logic [2:0] OC_OR  = 3'd3;
  localparam logic [2:0] OC_XOR = 3'd4;
  localparam logic [2:0] OC_LSL = 3'd5;
  localparam logic [2:0] OC_LSR = 3'd6;
  localparam logic [2:0] OC_MUL = 3'd7;

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_nzcv;

  logic [WIDTH-1:0] w_op2;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH:0]   w_ext;
  logic [SHW-1:0]   w_amt;
  logic             w_c;
  logic             w_v;
  logic [3:0]       w_nzcv;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_start_mul;

`ifdef EXE_PIPE_FAST_MUL_EN
  assign w_start_mul = 1'b0;
  assign bus.busy    = 1'b0;
`else
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic             r_setf;
  logic [WIDTH-1:0] w_acc_nxt;

  assign w_start_mul = (bus.alu_oc == OC_MUL);
  assign bus.busy    = (r_state == S_MUL);
  assign w_acc_nxt   = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

  assign w_in_ready      = (r_state == S_IDLE) | ((r_state == S_HOLD) & bus.out_ready);
  assign w_accept        = bus.in_valid & w_in_ready & ~bus.flush;
  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = (r_state == S_HOLD);
  assign bus.result      = r_result;
  assign bus.wr_cpsr_val = {r_nzcv, 28'd0};

  assign w_op2 = bus.ir_op ? bus.reg2_val : bus.immediate;
  assign w_amt = w_op2[SHW-1:0];

  // Shifts run one bit wider so the last bit shifted out lands in w_ext as C.
  always_comb begin
    w_ext = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (bus.alu_oc)
      OC_ADD: begin
        w_ext = {1'b0, bus.reg1_val} + {1'b0, w_op2};
        w_res = w_ext[WIDTH-1:0];
        w_c   = w_ext[WIDTH];
        w_v   = (bus.reg1_val[WIDTH-1] == w_op2[WIDTH-1]) & (w_res[WIDTH-1] != bus.reg1_val[WIDTH-1]);
      end
      OC_SUB: begin
        w_ext = {1'b0, bus.reg1_val} - {1'b0, w_op2};
        w_res = w_ext[WIDTH-1:0];
        w_c   = ~w_ext[WIDTH];
        w_v   = (bus.reg1_val[WIDTH-1] != w_op2[WIDTH-1]) & (w_res[WIDTH-1] != bus.reg1_val[WIDTH-1]);
      end
      OC_AND: w_res = bus.reg1_val & w_op2;
      OC_OR:  w_res = bus.reg1_val | w_op2;
      OC_XOR: w_res = bus.reg1_val ^ w_op2;
      OC_LSL: begin
        w_ext = {1'b0, bus.reg1_val} << w_amt;
        w_res = w_ext[WIDTH-1:0];
        w_c   = w_ext[WIDTH];
      end
      OC_LSR: begin
        w_ext = {bus.reg1_val, 1'b0} >> w_amt;
        w_res = w_ext[WIDTH:1];
        w_c   = w_ext[0];
      end
      default: begin
`ifdef EXE_PIPE_FAST_MUL_EN
        w_res = bus.reg1_val * w_op2;
`else
        w_res = '0;
`endif
      end
    endcase
  end

  assign w_nzcv = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_nzcv   <= '0;
`ifndef EXE_PIPE_FAST_MUL_EN
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_setf   <= 1'b0;
`endif
    end else if (bus.flush) begin
      r_state <= S_IDLE;
`ifndef EXE_PIPE_FAST_MUL_EN
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_accept) begin
            if (w_start_mul) begin
              r_state  <= S_MUL;
`ifndef EXE_PIPE_FAST_MUL_EN
              r_cnt    <= '0;
              r_mcand  <= bus.reg1_val;
              r_mplier <= w_op2;
              r_acc    <= '0;
              r_setf   <= bus.set_flags;
`endif
            end else begin
              r_state  <= S_HOLD;
              r_result <= w_res;
              if (bus.set_flags) r_nzcv <= w_nzcv;
            end
          end else if ((r_state == S_HOLD) && bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
`ifndef EXE_PIPE_FAST_MUL_EN
        S_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + SHW'(1);
          if (r_cnt == SHW'(WIDTH - 1)) begin
            r_state  <= S_HOLD;
            r_result <= w_acc_nxt;
            r_cnt    <= '0;
            if (r_setf) r_nzcv <= {w_acc_nxt[WIDTH-1], (w_acc_nxt == '0), 2'b00};
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exe_pipe.sv
// Directed bench for exe_pipe (default build, WIDTH=32).
// Expected values are hand-computed constants.
module tb_exe_pipe;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  always #5 clk = ~clk;

  exe_pipe_if #(.WIDTH(W)) ifc ();

  exe_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] oc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic ir, input logic sf);
    ifc.alu_oc    = oc;
    ifc.reg1_val  = a;
    ifc.reg2_val  = b;
    ifc.immediate = imm;
    ifc.ir_op     = ir;
    ifc.set_flags = sf;
    ifc.in_valid  = 1'b1;
    #1;
    chk("issue_in_ready", ifc.in_ready, 1);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nbusy;
    logic seen;
    n_checks = 0;
    n_errors = 0;
    rst_n         = 1'b0;
    ifc.flush     = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.reg1_val  = '0;
    ifc.reg2_val  = '0;
    ifc.immediate = '0;
    ifc.alu_oc    = 3'd0;
    ifc.ir_op     = 1'b0;
    ifc.set_flags = 1'b0;
    ifc.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_result", ifc.result, 0);
    chk("rst_cpsr", ifc.wr_cpsr_val, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_in_ready", ifc.in_ready, 1);
    tick();
    rst_n = 1'b1;

    issue(3'd0, 32'h7FFF_FFFF, 32'h0, 32'h1, 1'b0, 1'b1);
    chk("add_valid", ifc.out_valid, 1);
    chk("add_result", ifc.result, 32'h8000_0000);
    chk("add_cpsr", ifc.wr_cpsr_val, 32'h9000_0000);

    issue(3'd1, 32'd5, 32'd5, 32'h0, 1'b1, 1'b1);
    chk("sub_eq_result", ifc.result, 0);
    chk("sub_eq_cpsr", ifc.wr_cpsr_val, 32'h6000_0000);

    issue(3'd1, 32'd1, 32'd2, 32'h0, 1'b1, 1'b0);
    chk("sub_nf_result", ifc.result, 32'hFFFF_FFFF);
    chk("sub_nf_cpsr", ifc.wr_cpsr_val, 32'h6000_0000);

    issue(3'd5, 32'h8000_0001, 32'h0, 32'h1, 1'b0, 1'b1);
    chk("lsl_result", ifc.result, 32'h0000_0002);
    chk("lsl_cpsr", ifc.wr_cpsr_val, 32'h2000_0000);

    issue(3'd6, 32'h8000_0001, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("lsr0_result", ifc.result, 32'h8000_0001);
    chk("lsr0_cpsr", ifc.wr_cpsr_val, 32'h8000_0000);

    issue(3'd6, 32'h8000_0001, 32'h0, 32'h21, 1'b0, 1'b1);
    chk("lsr_amt_result", ifc.result, 32'h4000_0000);
    chk("lsr_amt_cpsr", ifc.wr_cpsr_val, 32'h2000_0000);

    issue(3'd0, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 1'b1);
    chk("add_c_result", ifc.result, 0);
    chk("add_c_cpsr", ifc.wr_cpsr_val, 32'h6000_0000);
    tick();
    chk("idle_after_drain", ifc.out_valid, 0);

    // MUL aborted by flush 10 cycles after acceptance
    issue(3'd7, 32'd3, 32'd4, 32'h0, 1'b1, 1'b1);
    chk("mulf_busy", ifc.busy, 1);
    chk("mulf_in_ready", ifc.in_ready, 0);
    repeat (9) tick();
    ifc.flush = 1'b1;
    tick();
    ifc.flush = 1'b0;
    chk("flush_busy", ifc.busy, 0);
    chk("flush_out_valid", ifc.out_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ifc.out_valid) seen = 1'b1;
      tick();
    end
    chk("flush_no_valid", seen, 0);
    chk("flush_cpsr", ifc.wr_cpsr_val, 32'h6000_0000);
    chk("flush_result", ifc.result, 0);

    issue(3'd7, 32'd1234, 32'd5678, 32'h0, 1'b1, 1'b1);
    ifc.reg1_val  = 32'hDEAD_BEEF;
    ifc.reg2_val  = 32'h1234_5678;
    ifc.set_flags = 1'b0;
    n = 0;
    nbusy = 0;
    while (!ifc.out_valid && n < 100) begin
      if (ifc.busy && !ifc.in_ready) nbusy++;
      tick();
      n++;
    end
    chk("mul_latency", n, 32);
    chk("mul_busy_cycles", nbusy, 32);
    chk("mul_result", ifc.result, 32'd7006652);
    chk("mul_cpsr", ifc.wr_cpsr_val, 32'h0);
    chk("mul_busy_done", ifc.busy, 0);
    tick();

    // Backpressure with a pending XOR
    ifc.out_ready = 1'b0;
    issue(3'd0, 32'd2, 32'h0, 32'd3, 1'b0, 1'b0);
    ifc.alu_oc    = 3'd4;
    ifc.reg1_val  = 32'hF0;
    ifc.immediate = 32'hFF;
    ifc.ir_op     = 1'b0;
    ifc.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_result", ifc.result, 32'd5);
      chk("bp_valid", ifc.out_valid, 1);
      chk("bp_in_ready", ifc.in_ready, 0);
      tick();
    end
    ifc.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", ifc.in_ready, 1);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    chk("bp_xor_result", ifc.result, 32'h0F);
    chk("bp_xor_valid", ifc.out_valid, 1);
    tick();
    chk("bp_drained", ifc.out_valid, 0);

    // Asynchronous reset while holding a result
    ifc.out_ready = 1'b0;
    issue(3'd0, 32'h7FFF_FFFF, 32'h0, 32'h1, 1'b0, 1'b1);
    chk("hold_cpsr", ifc.wr_cpsr_val, 32'h9000_0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", ifc.out_valid, 0);
    chk("arst_result", ifc.result, 0);
    chk("arst_cpsr", ifc.wr_cpsr_val, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
